// File: rtl/rv_enc_pkg.sv
// Shared constants for the RV32I instruction encoder: command class codes,
// the 7-bit major opcodes they map to, and the shift func3 values.
package rv_enc_pkg;

    localparam logic [3:0] OP_R      = 4'd0;
    localparam logic [3:0] OP_I      = 4'd1;
    localparam logic [3:0] OP_LOAD   = 4'd2;
    localparam logic [3:0] OP_STORE  = 4'd3;
    localparam logic [3:0] OP_BRANCH = 4'd4;
    localparam logic [3:0] OP_JAL    = 4'd5;
    localparam logic [3:0] OP_LUI    = 4'd6;
    localparam logic [3:0] OP_AUIPC  = 4'd7;
    localparam logic [3:0] OP_JALR   = 4'd8;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/rv_instr_fifo.sv
// DEPTH-entry, 32-bit synchronous FIFO with occupancy count; the head word
// reads as zero while empty so the sink never sees stale data.
module rv_instr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [31:0]              din,
    output logic [31:0]              dout,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign full  = (fill == (AW+1)'(DEPTH));
    assign empty = (fill == '0);
    assign dout  = empty ? 32'd0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// Field-level command to RV32I word encoder feeding an output FIFO.
// Optional immediate/shamt range checking: define RV_ENC_RANGE_CHECK_EN.
module rv_instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_op,
    input  logic [2:0]             cmd_func3,
    input  logic                   cmd_func7_5,
    input  logic [4:0]             cmd_rd,
    input  logic [4:0]             cmd_rs1,
    input  logic [4:0]             cmd_rs2,
    input  logic [31:0]            cmd_imm,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [31:0]            instr,
    output logic                   err_illegal,
    output logic [$clog2(DEPTH):0] fill
);
    logic [31:0] enc_word;
    logic        legal;
    logic        is_shift;
    logic        accept;
    logic        full;
    logic        empty;

    assign is_shift = (cmd_op == OP_I) &&
                      ((cmd_func3 == F3_SLL) || (cmd_func3 == F3_SRX));

    always_comb begin
        enc_word = 32'd0;
        case (cmd_op)
            OP_R:      enc_word = {1'b0, cmd_func7_5, 5'd0, cmd_rs2, cmd_rs1, cmd_func3, cmd_rd, OPC_R};
            OP_I:      enc_word = is_shift
                                ? {1'b0, cmd_func7_5, 5'd0, cmd_imm[4:0], cmd_rs1, cmd_func3, cmd_rd, OPC_I}
                                : {cmd_imm[11:0], cmd_rs1, cmd_func3, cmd_rd, OPC_I};
            OP_LOAD:   enc_word = {cmd_imm[11:0], cmd_rs1, cmd_func3, cmd_rd, OPC_LOAD};
            OP_JALR:   enc_word = {cmd_imm[11:0], cmd_rs1, cmd_func3, cmd_rd, OPC_JALR};
            OP_STORE:  enc_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_func3, cmd_imm[4:0], OPC_STORE};
            OP_BRANCH: enc_word = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, cmd_func3,
                                   cmd_imm[4:1], cmd_imm[11], OPC_BRANCH};
            OP_JAL:    enc_word = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12], cmd_rd, OPC_JAL};
            OP_LUI:    enc_word = {cmd_imm[31:12], cmd_rd, OPC_LUI};
            OP_AUIPC:  enc_word = {cmd_imm[31:12], cmd_rd, OPC_AUIPC};
            default:   enc_word = 32'd0;
        endcase
    end

`ifdef RV_ENC_RANGE_CHECK_EN
    // A signed value fits an N-bit field when every bit above the sign bit matches it.
    always_comb begin
        legal = 1'b1;
        case (cmd_op)
            OP_R:              legal = 1'b1;
            OP_I:              legal = is_shift ? (cmd_imm[31:5] == '0)
                                                : (cmd_imm[31:11] == {21{cmd_imm[11]}});
            OP_LOAD, OP_STORE,
            OP_JALR:           legal = (cmd_imm[31:11] == {21{cmd_imm[11]}});
            OP_BRANCH:         legal = (cmd_imm[31:12] == {20{cmd_imm[12]}}) && !cmd_imm[0];
            OP_JAL:            legal = (cmd_imm[31:20] == {12{cmd_imm[20]}}) && !cmd_imm[0];
            OP_LUI, OP_AUIPC:  legal = (cmd_imm[11:0] == 12'd0);
            default:           legal = 1'b0;
        endcase
    end
`else
    logic unused_imm_lsb;
    assign unused_imm_lsb = cmd_imm[0];
    assign legal = (cmd_op <= OP_JALR);
`endif

    assign cmd_ready   = !full;
    assign instr_valid = !empty;
    assign accept      = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= accept && !legal;
        end
    end

    rv_instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept && legal),
        .pop   (instr_valid && instr_ready),
        .din   (enc_word),
        .dout  (instr),
        .fill  (fill),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder: encodes, back-pressure, illegal drop, reset.
module tb_rv_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_func3;
    logic        cmd_func7_5;
    logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [31:0] cmd_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        err_illegal;
    logic [2:0]  fill;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        f75;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    rv_instr_encoder #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_func3   (cmd_func3),
        .cmd_func7_5 (cmd_func7_5),
        .cmd_rd      (cmd_rd),
        .cmd_rs1     (cmd_rs1),
        .cmd_rs2     (cmd_rs2),
        .cmd_imm     (cmd_imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .err_illegal (err_illegal),
        .fill        (fill)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [3:0] op, input logic [2:0] f3, input logic f75,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        cmd_op = op; cmd_func3 = f3; cmd_func7_5 = f75;
        cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    endtask

    // Present one command for a single edge; caller checks the cycle after.
    task automatic send(input logic [3:0] op, input logic [2:0] f3, input logic f75,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        set_cmd(op, f3, f75, rd, rs1, rs2, imm);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; instr_ready = 1'b0;
        set_cmd(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", fill); end
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++;
        if (err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_illegal); end
        checks++;
        if (instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h want 00000000", instr); end
    endtask

    task automatic test_encode();
        vec_t v [8];
        v[0] = '{4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3};
        v[1] = '{4'd0, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0,          32'h407302B3};
        v[2] = '{4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093};
        v[3] = '{4'd6, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000,   32'h123452B7};
        v[4] = '{4'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423};
        v[5] = '{4'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,          32'h40315093};
        v[6] = '{4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,          32'h008000EF};
        v[7] = '{4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h00208463};
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(v[i].op, v[i].f3, v[i].f75, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            checks++;
            if (instr_valid !== 1'b1 || instr !== v[i].exp) begin
                errors++;
                $display("FAIL encode_%0d got valid=%b instr=%h want valid=1 instr=%h",
                         i, instr_valid, instr, v[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [5];
        logic        acc;
        for (int i = 0; i < 5; i++) w[i] = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(4'd1, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
            cmd_valid = 1'b1;
            checks++;
            if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %b want 1", i, cmd_ready); end
            tick();
        end
        set_cmd(4'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd4);
        checks++;
        if (cmd_ready !== 1'b0 || fill !== 3'd4) begin
            errors++;
            $display("FAIL b2b_full got ready=%b fill=%0d want ready=0 fill=4", cmd_ready, fill);
        end
        tick();
        checks++;
        if (fill !== 3'd4) begin errors++; $display("FAIL b2b_hold_fill got %0d want 4", fill); end
        instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== w[k]) begin
                errors++;
                $display("FAIL b2b_drain_%0d got valid=%b instr=%h want valid=1 instr=%h",
                         k, instr_valid, instr, w[k]);
            end
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) cmd_valid = 1'b0;
        end
        checks++;
        if (fill !== 3'd0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got fill=%0d fifth_pending=%b want fill=0 pending=0", fill, cmd_valid);
        end
    endtask

    task automatic test_illegal();
        instr_ready = 1'b0;
        send(4'd1, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'd1);
        send(4'd12, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
        checks++;
        if (err_illegal !== 1'b1 || fill !== 3'd1) begin
            errors++;
            $display("FAIL illegal_drop got err=%b fill=%0d want err=1 fill=1", err_illegal, fill);
        end
        tick();
        checks++;
        if (err_illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse_width got %b want 0", err_illegal); end
        checks++;
        if (instr !== 32'h00100493) begin errors++; $display("FAIL illegal_head got %h want 00100493", instr); end
        instr_ready = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL illegal_drain got %b want 0", instr_valid); end
    endtask

    task automatic test_branch_odd();
        instr_ready = 1'b1;
        send(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
`ifdef RV_ENC_RANGE_CHECK_EN
        checks++;
        if (err_illegal !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL branch_odd got err=%b valid=%b want err=1 valid=0", err_illegal, instr_valid);
        end
`else
        checks++;
        if (err_illegal !== 1'b0 || instr_valid !== 1'b1 || instr !== 32'h00208163) begin
            errors++;
            $display("FAIL branch_odd got err=%b valid=%b instr=%h want err=0 valid=1 instr=00208163",
                     err_illegal, instr_valid, instr);
        end
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b0;
        send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
        send(4'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2);
        checks++;
        if (fill !== 3'd2) begin errors++; $display("FAIL midrst_pre_fill got %0d want 2", fill); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (fill !== 3'd0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear got fill=%0d valid=%b want fill=0 valid=0", fill, instr_valid);
        end
        instr_ready = 1'b1;
        send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h002081B3) begin
            errors++;
            $display("FAIL midrst_after got valid=%b instr=%h want valid=1 instr=002081B3", instr_valid, instr);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_encode();
        test_back_to_back();
        test_illegal();
        test_branch_odd();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
